// File: rtl/skill_delta_tracker.sv
// Two-stage decoder for the per-year experience word: skill population, gained/lost deltas and a saturating gained total.
// Optional coffee-run alarm is built only when SKILL_TRACKER_COFFEE_ALARM_EN is defined.
module skill_delta_tracker #(
  parameter int unsigned COFFEE_RUN = 3,
  parameter int unsigned TOTAL_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_word,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4:0]         skill_count,
  output logic [4:0]         gained,
  output logic [4:0]         lost,
  output logic [TOTAL_W-1:0] total_gained,
  output logic [2:0]         coffee,
  output logic               coffee_alarm
);

  logic               en;
  logic               s1_valid;
  logic [31:0]        s1_word;
  logic [22:0]        prev;
  logic [4:0]         sc_c;
  logic [4:0]         gained_c;
  logic [4:0]         lost_c;
  logic [TOTAL_W:0]   sum;
  logic [TOTAL_W-1:0] total_next;
  logic               unused_bits;

  function automatic logic [4:0] popcount23(input logic [22:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 23; i++) c = c + 5'(v[i]);
    return c;
  endfunction

  assign en          = !out_valid || out_ready;
  assign in_ready    = en;
  assign unused_bits = ^s1_word[5:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_word  <= in_word;
    end
  end

  // Deltas are taken against the last word that actually reached stage 2.
  always_comb begin
    sc_c       = popcount23(s1_word[31:9]);
    gained_c   = popcount23(s1_word[31:9] & ~prev);
    lost_c     = popcount23(~s1_word[31:9] & prev);
    sum        = {1'b0, total_gained} + (TOTAL_W + 1)'(gained_c);
    total_next = sum[TOTAL_W] ? {TOTAL_W{1'b1}} : sum[TOTAL_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      skill_count <= '0;
      gained      <= '0;
      lost        <= '0;
      coffee      <= '0;
    end else if (en) begin
      out_valid   <= s1_valid;
      skill_count <= sc_c;
      gained      <= gained_c;
      lost        <= lost_c;
      coffee      <= s1_word[8:6];
    end
  end

  // History only moves on real words so bubbles never disturb the deltas.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev         <= '0;
      total_gained <= '0;
    end else if (s1_valid && en) begin
      prev         <= s1_word[31:9];
      total_gained <= total_next;
    end
  end

`ifdef SKILL_TRACKER_COFFEE_ALARM_EN
  logic [3:0] run_cnt;
  logic [3:0] run_next;

  always_comb begin
    run_next = 4'd0;
    if (s1_word[8:6] == 3'd7) run_next = (run_cnt == 4'd15) ? 4'd15 : run_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt      <= 4'd0;
      coffee_alarm <= 1'b0;
    end else if (s1_valid && en) begin
      run_cnt      <= run_next;
      coffee_alarm <= (32'(run_next) >= COFFEE_RUN);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg   = (COFFEE_RUN == 0);
  assign coffee_alarm = 1'b0;
`endif

endmodule

// File: tb/tb_skill_delta_tracker.sv
// Scoreboard bench for skill_delta_tracker: directed words push hand-computed results, a negedge monitor pops and compares.
// A second instance with TOTAL_W=5 shares the inputs to exercise narrow saturation.
module tb_skill_delta_tracker;

  localparam logic [31:0] WA = 32'h7FFF_FF61;
  localparam logic [31:0] WB = 32'h0E06_3FDF;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_word;

  logic       in_ready, out_valid, coffee_alarm;
  logic [4:0] skill_count, gained, lost;
  logic [7:0] total_gained;
  logic [2:0] coffee;

  logic       in_ready5, out_valid5, coffee_alarm5;
  logic [4:0] skill_count5, gained5, lost5, total_gained5;
  logic [2:0] coffee5;

  typedef struct {
    logic [4:0] sc;
    logic [4:0] g;
    logic [4:0] l;
    logic [2:0] cf;
    logic       al;
    logic [7:0] t8;
    logic [4:0] t5;
  } exp_t;

  exp_t sb[$];
  exp_t front;
  int   checks = 0;
  int   fails  = 0;
  int   tot8   = 0;
  int   tot5   = 0;

  skill_delta_tracker #(.COFFEE_RUN(3), .TOTAL_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready), .skill_count(skill_count), .gained(gained),
    .lost(lost), .total_gained(total_gained), .coffee(coffee), .coffee_alarm(coffee_alarm)
  );

  skill_delta_tracker #(.COFFEE_RUN(3), .TOTAL_W(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready5), .in_word(in_word),
    .out_valid(out_valid5), .out_ready(out_ready), .skill_count(skill_count5), .gained(gained5),
    .lost(lost5), .total_gained(total_gained5), .coffee(coffee5), .coffee_alarm(coffee_alarm5)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: compare the presented result with the oldest expectation, pop on handoff.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checkOutput("in_ready_vs_stall", in_ready, (out_valid && !out_ready) ? 0 : 1);
      if (out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_result", out_valid, 0);
        end else begin
          front = sb[0];
          checkOutput("skill_count", skill_count, front.sc);
          checkOutput("gained", gained, front.g);
          checkOutput("lost", lost, front.l);
          checkOutput("coffee", coffee, front.cf);
          checkOutput("coffee_alarm", coffee_alarm, front.al);
          checkOutput("total_gained", total_gained, front.t8);
          checkOutput("total_gained_w5", total_gained5, front.t5);
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] word, input int sc, input int g, input int l,
                               input int cf, input logic al);
    exp_t e;
    int   n;
    tot8 = (tot8 + g > 255) ? 255 : tot8 + g;
    tot5 = (tot5 + g > 31) ? 31 : tot5 + g;
    e.sc = 5'(sc);
    e.g  = 5'(g);
    e.l  = 5'(l);
    e.cf = 3'(cf);
`ifdef SKILL_TRACKER_COFFEE_ALARM_EN
    e.al = al;
`else
    e.al = 1'b0;
`endif
    e.t8 = 8'(tot8);
    e.t5 = 5'(tot5);
    @(negedge clk);
    in_valid = 1'b1;
    in_word  = word;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkOutput("accept_timeout", in_ready, 1);
    @(posedge clk);
    sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_word  = 32'd0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) checkOutput("drain_timeout", sb.size(), 0);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_word   = 32'd0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_skill_count", skill_count, 0);
    checkOutput("rst_gained", gained, 0);
    checkOutput("rst_lost", lost, 0);
    checkOutput("rst_total", total_gained, 0);
    checkOutput("rst_total_w5", total_gained5, 0);
    checkOutput("rst_coffee", coffee, 0);
    checkOutput("rst_alarm", coffee_alarm, 0);
    sb.delete();
    tot8 = 0;
    tot5 = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("in_ready_after_rst", in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_word   = 32'd0;
    out_ready = 1'b1;

    // Single word and its latency.
    resetDut();
    applyStimulus(WA, 22, 22, 0, 5, 1'b0);
    idle();
    checkOutput("latency_edge_n", out_valid, 0);
    @(negedge clk);
    checkOutput("latency_edge_n1", out_valid, 1);
    drain();

    // Back-to-back, results on consecutive cycles.
    resetDut();
    applyStimulus(WB, 10, 10, 0, 7, 1'b0);
    applyStimulus(WA, 22, 12, 0, 5, 1'b0);
    idle();
    checkOutput("b2b_first_cycle", skill_count, 10);
    @(negedge clk);
    checkOutput("b2b_second_cycle", skill_count, 22);
    drain();

    // Lost skills.
    resetDut();
    applyStimulus(WA, 22, 22, 0, 5, 1'b0);
    applyStimulus(WB, 10, 0, 12, 7, 1'b0);
    idle();
    drain();

    // Downstream stall with three words offered.
    resetDut();
    @(negedge clk);
    out_ready = 1'b0;
    fork
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join_none
    applyStimulus(WB, 10, 10, 0, 7, 1'b0);
    applyStimulus(WB, 10, 0, 0, 7, 1'b0);
    applyStimulus(WA, 22, 12, 0, 5, 1'b0);
    idle();
    drain();

    // Coffee run.
    resetDut();
    applyStimulus(WB, 10, 10, 0, 7, 1'b0);
    applyStimulus(WB, 10, 0, 0, 7, 1'b0);
    applyStimulus(WB, 10, 0, 0, 7, 1'b1);
    applyStimulus(WA, 22, 12, 0, 5, 1'b0);
    idle();
    drain();

    // Saturation of both total widths.
    resetDut();
    for (int k = 0; k < 12; k++) begin
      applyStimulus(WA, 22, 22, 0, 5, 1'b0);
      applyStimulus(32'd0, 0, 0, 22, 0, 1'b0);
    end
    idle();
    drain();

    // Reset mid-stream clears in-flight words and history.
    applyStimulus(WA, 22, 22, 0, 5, 1'b0);
    applyStimulus(WB, 10, 0, 12, 7, 1'b0);
    resetDut();
    applyStimulus(WB, 10, 10, 0, 7, 1'b0);
    idle();
    drain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/skill_delta_tracker.md
# skill_delta_tracker

Downstream consumer of the per-year 32-bit experience word produced by the year-indexed skills lookup. It accepts one packed word per handshake and decodes its fields in a 2-stage pipeline. For each word it reports the skill population, the skills gained and lost relative to the previously accepted word, and a saturating running total of gained skills. An optional coffee-saturation alarm can be compiled in.

## Interface
Parameters:
- COFFEE_RUN, 3: consecutive accepted words with coffee field == 7 required to raise `coffee_alarm`; legal range 1..15.
- TOTAL_W, 8: width of `total_gained`; saturates at 2^TOTAL_W-1.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  `in_word` is valid.
- in_ready  out  1  block accepts `in_word` this cycle.
- in_word  in  32  packed experience word: [31:30] hw, [29:25] sw, [24:21] comm, [20:18] tools, [17:14] analysis, [13:9] misc, [8:6] coffee, [5:3] procrastination, [2:0] sleep.
- out_valid  out  1  result fields are valid.
- out_ready  in  1  downstream consumes the result this cycle.
- skill_count  out  5  popcount of `in_word[31:9]` (0..23).
- gained  out  5  popcount of `new[31:9] & ~prev[31:9]`.
- lost  out  5  popcount of `~new[31:9] & prev[31:9]`.
- total_gained  out  TOTAL_W  saturating sum of `gained` over all words.
- coffee  out  3  coffee field of the result word.
- coffee_alarm  out  1  coffee-run alarm; 0 when the feature is compiled out.

## Operation
- Accept: a word is accepted when `in_valid && in_ready` at a rising edge.
- Pipeline enable: `en = !out_valid || out_ready`.
  - `in_ready = en`, combinational from `out_valid` and `out_ready`; it never depends on `in_valid`.
- Stage 1 (advances on `en`):
  - Registers `in_word`, `s1_valid <= in_valid`.
  - Computes the three popcounts against `prev`.
- Stage 2 (advances on `en`):
  - Registers the popcounts and the coffee field.
  - `out_valid <= s1_valid`.
- When `s1_valid && en`:
  - `prev <= s1_word[31:9]`.
  - `total_gained <= min(total_gained + gained, 2^TOTAL_W-1)`.
  - The registered `total_gained` output reflects the word being presented.
- Bubbles (`s1_valid == 0`) leave `prev`, `total_gained` and the coffee-run counter untouched.
- First word after reset is compared against `prev == 0`, so `gained == skill_count` and `lost == 0`.
- Arithmetic: popcounts are 5-bit unsigned. The `total_gained` adder is TOTAL_W+1 bits wide and then clamps.

## Timing
- Reset values: `out_valid=0`, `skill_count=0`, `gained=0`, `lost=0`, `total_gained=0`, `coffee=0`, `coffee_alarm=0`, `prev=0`, `s1_valid=0`, run counter 0.
- `in_ready` is 1 one cycle after `rst` deasserts.
- Latency: a word accepted at edge N appears with `out_valid=1` after edge N+1, i.e. visible in cycle N+1 to N+2, when `out_ready` is held 1.
- Throughput: one word per cycle with `out_ready` held at 1.
- Stall: while `out_valid && !out_ready`, all outputs and both stages hold and `in_ready=0`. No word is lost or duplicated.
- Result handoff: the result transfers on the edge where `out_valid && out_ready`.
- Reset mid-operation: `rst` at any edge discards in-flight words and the history. Outputs return to reset values on that edge.

## Configuration
- SKILL_TRACKER_COFFEE_ALARM_EN defined:
  - A 4-bit run counter updates as each word enters stage 2: increments (saturating at 15) if coffee == 7, else clears to 0.
  - `coffee_alarm` is registered with stage 2 and is 1 when the new counter value >= COFFEE_RUN.
- Not defined: no counter is built and `coffee_alarm` is constant 0.

## Test plan
- Reset, then single word 0x7FFFFF61 -> 2 cycles later `out_valid=1`, `skill_count=22`, `gained=22`, `lost=0`, `total_gained=22`, `coffee=5`.
- Back-to-back 0x0E063FDF then 0x7FFFFF61 with `out_ready=1` ->
  - first result: `skill_count=10`, `gained=10`, `lost=0`, `total=10`;
  - second result: `skill_count=22`, `gained=12`, `lost=0`, `total=22`;
  - results on consecutive cycles.
- 0x7FFFFF61 then 0x0E063FDF -> second result `gained=0`, `lost=12`, `total_gained=22`.
- `out_ready=0` for 5 cycles with 3 words offered -> outputs frozen, `in_ready=0`, all 3 results later delivered in order with no duplicates.
- With SKILL_TRACKER_COFFEE_ALARM_EN, COFFEE_RUN=3: feed 0x0E063FDF ×3 then 0x7FFFFF61 -> `coffee_alarm` is 0, 0, 1, 0 on the four results. Without the macro -> always 0.
- TOTAL_W=5: feed 0x7FFFFF61, 0, 0x7FFFFF61 -> `total_gained` 22, 22, 31 (saturated). Assert `rst` mid-stream -> all outputs 0 on the next edge.
